// File: rtl/seq_alu.sv
// EX-stage ALU with registered results, start/busy/done handshake and an
// iterative shift-add multiplier / restoring divider writing HI/LO.
module seq_alu #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       firstOperand,
  input  logic [WIDTH-1:0]       secondOperand,
  input  logic [3:0]             aluControlInput,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic                   zero,
  output logic [WIDTH-1:0]       aluResult,
  output logic [WIDTH-1:0]       hi,
  output logic [WIDTH-1:0]       lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_e;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WIDTH - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opa_q, opa_d, opb_q, opb_d;
  logic                   neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic                   done_q, done_d, zero_q, zero_d;
  logic [WIDTH-1:0]       res_q, res_d, hi_q, hi_d, lo_q, lo_d;

  // mult/div (11xx) are signed when opcode bit 0 is clear
  logic             sgn, a_neg, b_neg, is_md;
  logic [WIDTH-1:0] a_abs, b_abs, simple;

  assign is_md = (aluControlInput[3:2] == 2'b11);
  assign sgn   = ~aluControlInput[0];
  assign a_neg = sgn & firstOperand[WIDTH-1];
  assign b_neg = sgn & secondOperand[WIDTH-1];
  assign a_abs = a_neg ? -firstOperand  : firstOperand;
  assign b_abs = b_neg ? -secondOperand : secondOperand;

  always_comb begin
    simple = '0;
    unique case (aluControlInput)
      4'b0000: simple = firstOperand & secondOperand;
      4'b0001: simple = firstOperand | secondOperand;
      4'b0010: simple = firstOperand + secondOperand;
      4'b0011: simple = secondOperand << shamt;
      4'b0100: simple = secondOperand >> shamt;
      4'b0101: simple = $signed(secondOperand) >>> shamt;
      4'b0110: simple = firstOperand - secondOperand;
      4'b0111: simple = {{(WIDTH-1){1'b0}}, $signed(firstOperand) < $signed(secondOperand)};
      4'b1000: simple = firstOperand ^ secondOperand;
      4'b1001: simple = hi_q;
      4'b1010: simple = lo_q;
      4'b1011: simple = {{(WIDTH-1){1'b0}}, firstOperand < secondOperand};
      default: simple = '0;
    endcase
  end

  // Multiply: acc = {partial product, multiplier}; add magnitude then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_prod;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_prod = neg_q ? -mul_next : mul_next;

  // Divide: acc = {remainder, dividend bits}; shift in one bit, subtract if it fits.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff, quo, rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign div_diff = div_sh[WIDTH-1:0] - opb_q;
  assign div_next = {div_ge ? div_diff : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  assign quo      = neg_q  ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
  assign rem      = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          zero_d = (firstOperand == secondOperand);
          cnt_d  = '0;
          if (is_md) begin
            opa_d  = firstOperand;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            dz_d   = (secondOperand == '0);
            if (aluControlInput[1]) begin
              state_d = DIV;
              acc_d   = {{WIDTH{1'b0}}, a_abs};
              opb_d   = b_abs;
            end else begin
              state_d = MUL;
              acc_d   = {{WIDTH{1'b0}}, b_abs};
              opb_d   = a_abs;
            end
          end else begin
            res_d  = simple;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = mul_prod[2*WIDTH-1:WIDTH];
          lo_d    = mul_prod[WIDTH-1:0];
          res_d   = mul_prod[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          // divide-by-zero: all-ones quotient, raw dividend as remainder
          hi_d    = dz_q ? opa_q : rem;
          lo_d    = dz_q ? '1    : quo;
          res_d   = dz_q ? '1    : quo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign zero      = zero_q;
  assign aluResult = res_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized + directed scoreboard bench for seq_alu (WIDTH=32).
`timescale 1ns/1ps
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] firstOperand = '0, secondOperand = '0;
  logic [3:0]  aluControlInput = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero;
  logic [31:0] aluResult, hi, lo;

  seq_alu dut (
    .clk(clk), .reset(reset), .start(start),
    .firstOperand(firstOperand), .secondOperand(secondOperand),
    .aluControlInput(aluControlInput), .shamt(shamt),
    .busy(busy), .done(done), .zero(zero),
    .aluResult(aluResult), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res, hi, lo;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mhi = '0, mlo = '0;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: architectural result from plain arithmetic; updates HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output exp_t e);
    longint             sa, sbv;
    logic [63:0]        p;
    logic signed [31:0] t;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    t   = b;
    e.z = (a == b);
    e.res = '0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd3:  e.res = b << sh;
      4'd4:  e.res = b >> sh;
      4'd5:  e.res = t >>> sh;
      4'd6:  e.res = a - b;
      4'd7:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
      4'd8:  e.res = a ^ b;
      4'd9:  e.res = mhi;
      4'd10: e.res = mlo;
      4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd12: begin p = sa * sbv; mhi = p[63:32]; mlo = p[31:0]; end
      4'd13: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      4'd14: begin
        if (b == 0) begin mlo = '1; mhi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mlo = a; mhi = '0; end
        else begin mlo = 32'(sa / sbv); mhi = 32'(sa % sbv); end
      end
      default: begin
        if (b == 0) begin mlo = '1; mhi = a; end
        else begin mlo = a / b; mhi = a % b; end
      end
    endcase
    if (op >= 4'd12) e.res = mlo;
    e.hi = mhi;
    e.lo = mlo;
  endtask

  // Issue one op; b2b=1 drives start in the current (done) cycle. poke>=0 fires a
  // stray start during that iteration cycle of a mult/div, which must be ignored.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit b2b, input int poke);
    exp_t e;
    bit   md;
    if (!b2b) begin @(posedge clk); #1; end
    start = 1'b1; aluControlInput = op; firstOperand = a; secondOperand = b; shamt = sh;
    model(op, a, b, sh, e);
    md = (op >= 4'd12);
    @(posedge clk); #1;
    start = 1'b0; firstOperand = $urandom; secondOperand = $urandom;
    e.cyc = md ? cyc + 32 : cyc;
    sb.push_back(e);
    if (!md) @(negedge clk);
    else for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      chk("busy", busy, (k < 32));
      if (k == poke) begin
        start = 1'b1; aluControlInput = 4'd2; firstOperand = 32'h55; secondOperand = 32'h55;
      end else if (k == poke + 1) start = 1'b0;
    end
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        checks--;
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("aluResult", aluResult, e.res);
        chk("zero", zero, e.z);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_zero", zero, 0);
    chk("rst_res", aluResult, 0); chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);

    // directed
    do_op(4'd2,  32'd7, 32'hFFFF_FFFD, 5'd0, 0, -1);
    do_op(4'd6,  32'd5, 32'd5, 5'd0, 0, -1);
    do_op(4'd5,  32'd0, 32'h8000_0010, 5'd4, 0, -1);
    do_op(4'd4,  32'd0, 32'h8000_0010, 5'd4, 1, -1);
    do_op(4'd3,  32'd0, 32'd1, 5'd31, 0, -1);
    do_op(4'd11, 32'd1, 32'hFFFF_FFFF, 5'd0, 0, -1);
    do_op(4'd7,  32'd1, 32'hFFFF_FFFF, 5'd0, 0, -1);
    do_op(4'd12, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, -1);
    do_op(4'd9,  32'd0, 32'd0, 5'd0, 0, -1);
    do_op(4'd13, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, -1);
    do_op(4'd9,  32'd0, 32'd0, 5'd0, 1, -1);
    do_op(4'd10, 32'd0, 32'd0, 5'd0, 0, -1);
    do_op(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd0, 0, -1);
    do_op(4'd15, 32'd7, 32'd0, 5'd0, 0, -1);
    do_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1, -1);
    do_op(4'd12, 32'h1234_5678, 32'hFFFF_0001, 5'd0, 0, 9);
    do_op(4'd2,  32'd1, 32'd2, 5'd0, 1, -1);

    // reset mid-divide after HI/LO = 0x12/0x34
    do_op(4'd15, 32'h692, 32'h20, 5'd0, 0, -1);
    @(posedge clk); #1;
    start = 1'b1; aluControlInput = 4'd14; firstOperand = 32'd1000; secondOperand = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_res", aluResult, 0);
    chk("abort_hi", hi, 0); chk("abort_lo", lo, 0);
    do_op(4'd2, 32'd10, 32'd20, 5'd0, 0, -1);
    do_op(4'd10, 32'd0, 32'd0, 5'd0, 0, -1);

    // randomized mix
    for (int i = 0; i < 60; i++)
      do_op(4'($urandom_range(0, 11)), rval(), rval(), 5'($urandom), 1'($urandom), -1);
    for (int i = 0; i < 16; i++) begin
      do_op(4'($urandom_range(12, 15)), rval(), rval(), 5'd0, 1'($urandom), -1);
      do_op(4'($urandom_range(9, 10)), rval(), rval(), 5'd0, 1'($urandom), -1);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
